// File: rtl/rv32_pkg.sv
// rv32_pkg: RV32 opcodes, one-hot format indices and the ID/EX payload shared by the decode stage.
package rv32_pkg;
   localparam int XLEN = 32;
   localparam logic [6:0] OP     = 7'b0110011;
   localparam logic [6:0] OP_IMM = 7'b0010011;
   localparam logic [6:0] LOAD   = 7'b0000011;
   localparam logic [6:0] STORE  = 7'b0100011;
   localparam logic [6:0] BRANCH = 7'b1100011;
   localparam logic [6:0] JAL    = 7'b1101111;
   localparam logic [6:0] JALR   = 7'b1100111;
   localparam logic [6:0] LUI    = 7'b0110111;
   localparam logic [6:0] AUIPC  = 7'b0010111;
   localparam logic [6:0] SYSTEM = 7'b1110011;
   localparam int F_R = 0;
   localparam int F_I = 1;
   localparam int F_S = 2;
   localparam int F_B = 3;
   localparam int F_U = 4;
   localparam int F_J = 5;
   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [6:0]      opcode;
      logic [4:0]      rd;
      logic [2:0]      funct3;
      logic [6:0]      funct7;
      logic [4:0]      rs1;
      logic [4:0]      rs2;
      logic [XLEN-1:0] rs1_data;
      logic [XLEN-1:0] rs2_data;
      logic [XLEN-1:0] imm;
      logic [5:0]      fmt;
      logic            illegal;
   } idex_t;
   function automatic logic reg_ok(input logic [4:0] a, input int n);
      return {27'd0, a} < n;
   endfunction
endpackage

// File: rtl/decode_stage_if.sv
// decode_stage_if: fetch-to-decode valid/ready handshake carrying the instruction word and its PC.
interface decode_stage_if;
   import rv32_pkg::*;
   logic            valid;
   logic            ready;
   logic [XLEN-1:0] inst;
   logic [XLEN-1:0] pc;
   modport master (output valid, inst, pc, input ready);
   modport slave (input valid, inst, pc, output ready);
endinterface

// File: rtl/decode_regfile.sv
// decode_regfile: NUM_REGS x XLEN register file, x0 reads zero, two combinational read ports.
// Define DECODE_WB_BYPASS_EN to return same-cycle writeback data on a matching read (write-first).
module decode_regfile
   import rv32_pkg::*;
#(
   parameter int NUM_REGS = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            i_wen,
   input  logic [4:0]      i_waddr,
   input  logic [XLEN-1:0] i_wdata,
   input  logic [4:0]      i_raddr1,
   input  logic [4:0]      i_raddr2,
   output logic [XLEN-1:0] o_rdata1,
   output logic [XLEN-1:0] o_rdata2
);
   localparam int AW = $clog2(NUM_REGS);
   logic [XLEN-1:0] r_regs [NUM_REGS];
   logic            w_we;
   assign w_we = i_wen & (i_waddr != 5'd0) & reg_ok(i_waddr, NUM_REGS);
   always_ff @(posedge clk or posedge rst)
      if (rst) for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
      else if (w_we) r_regs[i_waddr[AW-1:0]] <= i_wdata;
   function automatic logic [XLEN-1:0] rd_port(input logic [4:0] a);
      if (a == 5'd0 || !reg_ok(a, NUM_REGS)) return '0;
`ifdef DECODE_WB_BYPASS_EN
      if (w_we && i_waddr == a) return i_wdata;
`endif
      return r_regs[a[AW-1:0]];
   endfunction
   always_comb begin
      o_rdata1 = rd_port(i_raddr1);
      o_rdata2 = rd_port(i_raddr2);
   end
endmodule

// File: rtl/decode_stage.sv
// decode_stage: RV32I/RV32E decode into an ID/EX register with flush, back-pressure and load-use stall.
// Optional DECODE_WB_BYPASS_EN (in decode_regfile) forwards same-cycle writeback data to operand reads.
module decode_stage
   import rv32_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_ADDR = 32'h00000000,
   parameter int              NUM_REGS   = 32
) (
   input  logic            clk,
   input  logic            rst,
   decode_stage_if.slave   i_fetch,
   input  logic            i_flush,
   input  logic            i_rd_wen,
   input  logic [4:0]      i_rd_waddr,
   input  logic [XLEN-1:0] i_rd_wdata,
   output logic            o_valid,
   input  logic            i_ready,
   output logic [XLEN-1:0] o_pc,
   output logic [6:0]      o_opcode,
   output logic [4:0]      o_rd,
   output logic [2:0]      o_funct3,
   output logic [6:0]      o_funct7,
   output logic [4:0]      o_rs1_addr,
   output logic [4:0]      o_rs2_addr,
   output logic [XLEN-1:0] o_rs1_rdata,
   output logic [XLEN-1:0] o_rs2_rdata,
   output logic [XLEN-1:0] o_immediate,
   output logic [5:0]      o_format,
   output logic            o_illegal
);
   idex_t           w_next, r_q;
   logic            r_valid, w_hazard, w_adv, w_acc, w_uj, w_illegal;
   logic [XLEN-1:0] w_inst, w_imm, w_rs1_data, w_rs2_data;
   logic [5:0]      w_fmt;
   logic [4:0]      w_rd, w_rs1, w_rs2;
   assign w_inst     = i_fetch.inst;
   assign w_fmt[F_R] = w_inst[6:0] == OP;
   assign w_fmt[F_I] = w_inst[6:0] inside {OP_IMM, LOAD, JALR, SYSTEM};
   assign w_fmt[F_S] = w_inst[6:0] == STORE;
   assign w_fmt[F_B] = w_inst[6:0] == BRANCH;
   assign w_fmt[F_U] = w_inst[6:0] inside {LUI, AUIPC};
   assign w_fmt[F_J] = w_inst[6:0] == JAL;
   assign w_uj       = w_fmt[F_U] | w_fmt[F_J];
   assign w_rd       = (w_fmt[F_S] | w_fmt[F_B]) ? 5'd0 : w_inst[11:7];
   assign w_rs1      = w_uj ? 5'd0 : w_inst[19:15];
   assign w_rs2      = (w_uj | w_fmt[F_I]) ? 5'd0 : w_inst[24:20];
   assign w_imm = w_fmt[F_I] ? {{20{w_inst[31]}}, w_inst[31:20]} :
                  w_fmt[F_S] ? {{20{w_inst[31]}}, w_inst[31:25], w_inst[11:7]} :
                  w_fmt[F_B] ? {{20{w_inst[31]}}, w_inst[7], w_inst[30:25], w_inst[11:8], 1'b0} :
                  w_fmt[F_U] ? {w_inst[31:12], 12'd0} :
                  w_fmt[F_J] ? {{12{w_inst[31]}}, w_inst[19:12], w_inst[20], w_inst[30:21], 1'b0} : '0;
   assign w_illegal = ~|w_fmt | ~reg_ok(w_rd, NUM_REGS) | ~reg_ok(w_rs1, NUM_REGS) | ~reg_ok(w_rs2, NUM_REGS);
   // A held load whose rd feeds the incoming instruction must leave before the dependent is accepted.
   assign w_hazard = r_valid & (r_q.opcode == LOAD) & (r_q.rd != 5'd0) & i_fetch.valid &
                     ((r_q.rd == w_rs1) | (r_q.rd == w_rs2));
   assign w_adv         = ~r_valid | i_ready;
   assign i_fetch.ready = w_adv & ~w_hazard & ~i_flush;
   assign w_acc         = i_fetch.valid & i_fetch.ready;
   assign w_next = '{pc: i_fetch.pc, opcode: w_inst[6:0], rd: w_rd,
                     funct3: w_uj ? 3'd0 : w_inst[14:12], funct7: w_fmt[F_R] ? w_inst[31:25] : 7'd0,
                     rs1: w_rs1, rs2: w_rs2, rs1_data: w_rs1_data, rs2_data: w_rs2_data,
                     imm: w_imm, fmt: w_illegal ? 6'd0 : w_fmt, illegal: w_illegal};
   decode_regfile #(.NUM_REGS(NUM_REGS)) u_rf (
      .clk      (clk),
      .rst      (rst),
      .i_wen    (i_rd_wen),
      .i_waddr  (i_rd_waddr),
      .i_wdata  (i_rd_wdata),
      .i_raddr1 (w_rs1),
      .i_raddr2 (w_rs2),
      .o_rdata1 (w_rs1_data),
      .o_rdata2 (w_rs2_data)
   );
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         r_valid <= 1'b0;
         r_q     <= '0;
         r_q.pc  <= RESET_ADDR;
      end else if (i_flush) r_valid <= 1'b0;
      else if (w_adv) begin
         r_valid <= w_acc;
         if (w_acc) r_q <= w_next;
      end
   assign o_valid     = r_valid;
   assign o_pc        = r_q.pc;
   assign o_opcode    = r_q.opcode;
   assign o_rd        = r_q.rd;
   assign o_funct3    = r_q.funct3;
   assign o_funct7    = r_q.funct7;
   assign o_rs1_addr  = r_q.rs1;
   assign o_rs2_addr  = r_q.rs2;
   assign o_rs1_rdata = r_q.rs1_data;
   assign o_rs2_rdata = r_q.rs2_data;
   assign o_immediate = r_q.imm;
   assign o_format    = r_q.fmt;
   assign o_illegal   = r_q.illegal;
endmodule
